// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    typedef logic [AUDIO_SAMPLE_W-1:0] sample_t;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and a combinational head.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   next_level;
    logic          do_push;
    logic          do_pop;

    // Push uses the registered full, so a write while full is dropped even if a pop frees a slot.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        next_level = level;
        if (do_push && !do_pop) next_level = level + 1'b1;
        if (do_pop && !do_push) next_level = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            level <= next_level;
            full  <= (next_level == FULL_CNT);
            empty <= (next_level == '0);
        end
    end

endmodule

// File: rtl/audio_tx_serializer.sv
// Tick-driven PCM serializer: FIFO, shift FSM and sticky status flags.
// Optional build macro: AUDIO_TX_HOLD_ON_UNDERRUN_EN (repeat last sample on underrun).
module audio_tx_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [31:0]              wdata_i,
    input  logic                     tick_i,
    input  logic                     clr_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     underrun_o,
    output logic                     overflow_o,
    output logic                     tick_miss_o,
    output logic                     busy_o,
    output logic                     sclk_o,
    output logic                     fs_o,
    output logic                     sdata_o
);

    localparam int CW = $clog2(SAMPLE_W);

    tx_state_t         state;
    logic              phase;
    logic [CW-1:0]     cnt;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] head;
    logic [SAMPLE_W-1:0] under_val;
    logic [SAMPLE_W-1:0] load;
    logic              last_bit;
    logic              start;
    logic              pop;

    generate
        if (SAMPLE_W < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^wdata_i[31:SAMPLE_W];
        end
    endgenerate

    sync_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (we_i),
        .pop   (pop),
        .wdata (wdata_i[SAMPLE_W-1:0]),
        .rdata (head),
        .full  (full_o),
        .empty (empty_o),
        .level (level_o)
    );

    // A tick on the final edge of a frame starts the next one back to back.
    assign last_bit = (state == TX_SHIFT) && phase && (cnt == '0);
    assign start    = tick_i && ((state == TX_IDLE) || last_bit);
    assign pop      = start && !empty_o;
    assign load     = empty_o ? under_val : head;

`ifdef AUDIO_TX_HOLD_ON_UNDERRUN_EN
    logic [SAMPLE_W-1:0] last_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      last_sample <= '0;
        else if (pop) last_sample <= head;
    end

    assign under_val = last_sample;
`else
    assign under_val = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            phase   <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            busy_o  <= 1'b0;
            sclk_o  <= 1'b0;
            fs_o    <= 1'b0;
            sdata_o <= 1'b0;
        end else if (start) begin
            state   <= TX_SHIFT;
            phase   <= 1'b0;
            cnt     <= CW'(SAMPLE_W-1);
            shreg   <= load;
            busy_o  <= 1'b1;
            sclk_o  <= 1'b0;
            fs_o    <= 1'b1;
            sdata_o <= load[SAMPLE_W-1];
        end else if (state == TX_SHIFT) begin
            if (!phase) begin
                phase  <= 1'b1;
                sclk_o <= 1'b1;
            end else if (cnt == '0) begin
                state   <= TX_IDLE;
                phase   <= 1'b0;
                busy_o  <= 1'b0;
                sclk_o  <= 1'b0;
                fs_o    <= 1'b0;
                sdata_o <= 1'b0;
            end else begin
                phase   <= 1'b0;
                cnt     <= cnt - 1'b1;
                shreg   <= shreg << 1;
                sclk_o  <= 1'b0;
                fs_o    <= 1'b0;
                sdata_o <= shreg[SAMPLE_W-2];
            end
        end
    end

    // Sticky flags: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_o  <= 1'b0;
            overflow_o  <= 1'b0;
            tick_miss_o <= 1'b0;
        end else begin
            underrun_o  <= (start && empty_o) || (underrun_o && !clr_i);
            overflow_o  <= (we_i && full_o) || (overflow_o && !clr_i);
            tick_miss_o <= (tick_i && !start) || (tick_miss_o && !clr_i);
        end
    end

endmodule

// File: doc/audio_tx_serializer.md
# audio_tx_serializer

Sample-rate output stage that sits directly downstream of the sample-rate timer. The CPU pushes PCM samples into an internal FIFO; each timer interrupt pulse pops one sample and shifts it out MSB-first on a serial DAC interface (bit clock, frame sync, data). Underrun, overflow and missed-tick conditions are flagged to software.

## Interface
- `SAMPLE_W`, 16: sample width in bits, range 8–32.
- `DEPTH`, 8: FIFO depth in samples; a power of two, at least 2.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `we_i` input, 1 bit: CPU write strobe; pushes one sample.
- `wdata_i` input, 32 bits: CPU write data; bits [SAMPLE_W-1:0] form the sample, the rest are ignored.
- `tick_i` input, 1 bit: sample-rate pulse from the timer `irq`, one cycle wide.
- `clr_i` input, 1 bit: clears all sticky flags.
- `full_o` output, 1 bit: FIFO full.
- `empty_o` output, 1 bit: FIFO empty.
- `level_o` output, $clog2(DEPTH)+1 bits: FIFO occupancy.
- `underrun_o` output, 1 bit: sticky; a tick arrived while the FIFO was empty.
- `overflow_o` output, 1 bit: sticky; a write arrived while the FIFO was full.
- `tick_miss_o` output, 1 bit: sticky; a tick arrived while a frame was still shifting.
- `busy_o` output, 1 bit: a frame is in progress.
- `sclk_o` output, 1 bit: serial bit clock.
- `fs_o` output, 1 bit: frame sync.
- `sdata_o` output, 1 bit: serial data, MSB first.

## Operation
- FIFO:
  - Synchronous, first-in first-out.
  - Push when `we_i` is high and the FIFO is not full.
  - Write when full: data dropped, `overflow_o` set.
  - Push and pop in the same cycle: both happen, level unchanged. Push-while-full is still dropped even if a pop occurs that cycle.
- The FSM has two states:
  - IDLE:
    - `tick_i` high: load the shift register, set the bit counter to SAMPLE_W-1, set phase to 0, go to SHIFT.
    - Load source when the FIFO is not empty: the FIFO head, popped in that cycle.
    - Load source when the FIFO is empty: underrun value (see Configuration); `underrun_o` set, no pop.
  - SHIFT:
    - `sdata_o` = shift register MSB.
    - Phase 0: `sclk_o` = 0.
    - Phase 1: `sclk_o` = 1. At the end of phase 1, shift left by one and decrement the counter. If the counter is 0, go to IDLE instead.
- `fs_o` = 1 for the first bit (2 cycles) only.
- `busy_o` = 1 when in SHIFT.
- `tick_i` while in SHIFT: ignored, `tick_miss_o` set, no pop.
- `clr_i`: clears all three sticky flags next edge. If `clr_i` coincides with a new flag event, set wins.
- In IDLE, `sclk_o`, `fs_o` and `sdata_o` are held at 0.
- Reset, including mid-frame:
  - FSM returns to IDLE, FIFO is emptied, shift register and last-sample register are cleared.
  - All outputs are 0 except `empty_o` = 1.

## Timing
- Tick sampled at edge k: `fs_o`, `busy_o` and `sdata_o` (bit SAMPLE_W-1) are valid after edge k. `level_o` drops by 1 after edge k.
- Each bit lasts 2 `clk` cycles. A frame lasts 2*SAMPLE_W cycles.
- `busy_o` falls after edge k+2*SAMPLE_W. A tick at that same edge is accepted (back-to-back frames).
- Minimum tick period for loss-free operation: 2*SAMPLE_W cycles.
- `full_o`, `empty_o` and `level_o` are registered and update the edge after a push or pop.
- No combinational path from any input to any output.

## Configuration
- `AUDIO_TX_HOLD_ON_UNDERRUN_EN`:
  - Defined: an underrun frame repeats the last successfully popped sample. This requires a SAMPLE_W-bit last-sample register, reset to 0.
  - Undefined: an underrun frame transmits all zeros and the register is omitted.
- The `underrun_o` flag behaviour is identical in both builds.

## Structure
- Package `audio_pkg` holds:
  - `AUDIO_SAMPLE_W` (default 16).
  - `typedef logic [AUDIO_SAMPLE_W-1:0] sample_t`.
  - `typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t`.
- Sub-module `sync_fifo`:
  - Parameterised width and depth.
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, level.
  - Reused by later audio blocks.
- Top level holds the FSM, phase and bit counters, shift register and sticky flags.

## Test plan
- Reset, then write 0xA5C3 and tick once → `fs_o` high for 2 cycles; `sdata_o` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 sampled on `sclk_o` rising edges; `busy_o` low after 32 cycles; `level_o` = 0.
- Write 8 samples, then a 9th → `full_o` = 1, `overflow_o` = 1, `level_o` = 8; the 9 ticks that follow emit the first 8 samples and then an underrun frame.
- Tick with the FIFO empty after sample 0x1234 → `underrun_o` = 1; frame = 0x1234 with `AUDIO_TX_HOLD_ON_UNDERRUN_EN`, 0x0000 without.
- Ticks every 20 cycles with SAMPLE_W = 16 → `tick_miss_o` = 1, one pop per completed frame only; a tick every 32 cycles → no miss, frames back to back.
- Assert `rst` at bit 7 of a frame with 3 samples queued → all outputs 0 immediately, `empty_o` = 1, `level_o` = 0; next tick produces an underrun frame.
- `clr_i` and a new underrun in the same cycle → `underrun_o` stays 1; `clr_i` alone → flags 0 next cycle.
